shift_seq_ctrl: RTL and testbench

Area-reduced multi-cycle shift unit for the execute stage. A single small-range shift datapath (0..MAX_STEP bits per cycle) is sequenced by this controller. The controller accepts a full 32-bit shift request over a valid/ready handshake, iterates until the full shift amount is consumed, and returns the result over a second valid/ready handshake. It replaces the single-cycle barrel shifter where timing or area requires it, and preserves SLL/SRL/SRA semantics.

---
 rtl/shift_seq_ctrl_if.sv | 30 +++
 rtl/shift_seq_ctrl.sv | 119 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle for the multi-cycle shift controller.
// Request side: valid_i, ready_o, a_i, shamt_i, right_i, arith_i, flush_i.
// Response side: valid_o, ready_i, result_o. Status: busy_o.
// master = requester/consumer side, slave = controller side.
interface shift_seq_ctrl_if;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  logic               valid_i;
  logic               ready_o;
  logic [DATA_W-1:0]  a_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic               right_i;
  logic               arith_i;
  logic               flush_i;
  logic               valid_o;
  logic               ready_i;
  logic [DATA_W-1:0]  result_o;
  logic               busy_o;

  modport master (
    output valid_i, a_i, shamt_i, right_i, arith_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, a_i, shamt_i, right_i, arith_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift controller: accepts a 32-bit shift request, consumes the
// shift amount in chunks of at most MAX_STEP bits per cycle, and returns the
// result over a valid/ready handshake. Supports SLL, SRL and SRA.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - slave side of shift_seq_ctrl_if (request, response, flush, busy)
module shift_seq_ctrl #(
  parameter int unsigned MAX_STEP = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  shift_seq_ctrl_if.slave  bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam logic [SHAMT_W-1:0] STEP_MAX = SHAMT_W'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state;
  logic [DATA_W-1:0]   acc;
  logic [SHAMT_W-1:0]  rem;
  logic                right_q;
  logic                arith_q;
  logic                ready_q;
  logic                valid_q;
  logic                busy_q;

  logic [SHAMT_W-1:0]  step_c;
  logic [SHAMT_W-1:0]  rem_next_c;
  logic [DATA_W-1:0]   acc_next_c;

  // One iteration of the narrow shift datapath; arithmetic fill comes from
  // bit 31 of the current accumulator so partial shifts compose exactly.
  always_comb begin
    step_c     = (rem > STEP_MAX) ? STEP_MAX : rem;
    rem_next_c = rem - step_c;
    if (!right_q) begin
      acc_next_c = acc << step_c;
    end else if (arith_q) begin
      acc_next_c = DATA_W'($signed(acc) >>> step_c);
    end else begin
      acc_next_c = acc >> step_c;
    end
  end

  // Sequencer: state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      acc     <= '0;
      rem     <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.flush_i) begin
      // Abort wins over acceptance and over a completing result handshake.
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.valid_i) begin
            acc     <= bus.a_i;
            rem     <= bus.shamt_i;
            right_q <= bus.right_i;
            arith_q <= bus.arith_i;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.shamt_i == '0) begin
              state   <= DONE;
              valid_q <= 1'b1;
            end else begin
              state   <= RUN;
            end
          end
        end
        RUN: begin
          acc <= acc_next_c;
          rem <= rem_next_c;
          if (rem_next_c == '0) begin
            state   <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.valid_o  = valid_q;
  assign bus.busy_o   = busy_q;
  assign bus.result_o = acc;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with MAX_STEP = 4.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_seq_ctrl_if bus ();

  shift_seq_ctrl #(.MAX_STEP(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure latency and busy cycles, apply stall cycles
  // in DONE (with a stray valid_i that must be ignored), then hand it off.
  task automatic run_req(input string tag, input logic [31:0] a, input logic [4:0] sh,
                         input logic r, input logic ar, input logic [31:0] exp,
                         input int exp_cyc, input int stall);
    int cnt;
    int busy_cnt;
    check({tag, "_ready_before"}, 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1;
    bus.a_i     = a;
    bus.shamt_i = sh;
    bus.right_i = r;
    bus.arith_i = ar;
    bus.ready_i = 1'b0;
    tick();
    bus.valid_i = 1'b0;
    bus.a_i     = 32'hA5A5_5A5A;
    bus.shamt_i = 5'd3;
    cnt      = 1;
    busy_cnt = bus.busy_o ? 1 : 0;
    while (!bus.valid_o && cnt < 40) begin
      tick();
      cnt++;
      if (bus.busy_o) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(exp_cyc));
    check({tag, "_result"}, bus.result_o, exp);
    for (int i = 0; i < stall; i++) begin
      bus.valid_i = 1'b1;
      tick();
      busy_cnt++;
      check({tag, "_stall_valid"}, 32'(bus.valid_o), 32'd1);
      check({tag, "_stall_ready"}, 32'(bus.ready_o), 32'd0);
      check({tag, "_stall_result"}, bus.result_o, exp);
    end
    bus.ready_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc + stall));
    check({tag, "_post_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_post_ready"}, 32'(bus.ready_o), 32'd1);
    check({tag, "_post_busy"}, 32'(bus.busy_o), 32'd0);
    // Stray valid_i during the handoff edge must not have been accepted.
    if (stall > 0) check({tag, "_not_accepted"}, bus.result_o, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.a_i     = '0;
    bus.shamt_i = '0;
    bus.right_i = 1'b0;
    bus.arith_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b0;
    #12;
    check("rst_ready",  32'(bus.ready_o), 32'd1);
    check("rst_valid",  32'(bus.valid_o), 32'd0);
    check("rst_busy",   32'(bus.busy_o),  32'd0);
    check("rst_result", bus.result_o,     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_req("sll31",   32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 9, 0);
    run_req("sra7",    32'h8000_00F0, 5'd7,  1'b1, 1'b1, 32'hFF00_0001, 3, 0);
    run_req("srl7",    32'h8000_00F0, 5'd7,  1'b1, 1'b0, 32'h0100_0001, 3, 0);
    run_req("sll0",    32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF, 1, 0);
    run_req("srl0",    32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF, 1, 0);
    run_req("sra0",    32'hDEAD_BEEF, 5'd0,  1'b1, 1'b1, 32'hDEAD_BEEF, 1, 0);
    run_req("sll4",    32'h1234_5678, 5'd4,  1'b0, 1'b0, 32'h2345_6780, 2, 0);
    run_req("sra31",   32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 9, 0);
    run_req("srl31",   32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 9, 0);
    run_req("srl16",   32'h1234_5678, 5'd16, 1'b1, 1'b0, 32'h0000_1234, 5, 0);
    run_req("sra5",    32'h8765_4321, 5'd5,  1'b1, 1'b1, 32'hFC3B_2A19, 3, 0);
    run_req("sra_pos", 32'h4000_0000, 5'd9,  1'b1, 1'b1, 32'h0020_0000, 4, 0);
    run_req("bp_sra7", 32'h8000_00F0, 5'd7,  1'b1, 1'b1, 32'hFF00_0001, 3, 5);

    // Flush on the second RUN cycle of a shamt=20 request.
    bus.valid_i = 1'b1;
    bus.a_i     = 32'hFFFF_FFFF;
    bus.shamt_i = 5'd20;
    bus.right_i = 1'b0;
    bus.arith_i = 1'b0;
    tick();
    bus.valid_i = 1'b0;
    check("fl_run1_busy", 32'(bus.busy_o), 32'd1);
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("fl_ready", 32'(bus.ready_o), 32'd1);
    check("fl_valid", 32'(bus.valid_o), 32'd0);
    check("fl_busy",  32'(bus.busy_o),  32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.valid_o) seen++;
      end
      check("fl_no_valid", 32'(seen), 32'd0);
    end
    run_req("fl_next", 32'h1234_5678, 5'd4, 1'b1, 1'b0, 32'h0123_4567, 2, 0);

    // Request presented together with flush is not accepted.
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.shamt_i = 5'd8;
    tick();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("fl_acc_ready", 32'(bus.ready_o), 32'd1);
    check("fl_acc_busy",  32'(bus.busy_o),  32'd0);

    // Asynchronous reset mid-RUN.
    bus.valid_i = 1'b1;
    bus.a_i     = 32'h0F0F_0F0F;
    bus.shamt_i = 5'd20;
    bus.right_i = 1'b1;
    bus.arith_i = 1'b0;
    tick();
    bus.valid_i = 1'b0;
    tick();
    check("rr_busy_before", 32'(bus.busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_ready",  32'(bus.ready_o), 32'd1);
    check("rr_valid",  32'(bus.valid_o), 32'd0);
    check("rr_busy",   32'(bus.busy_o),  32'd0);
    check("rr_result", bus.result_o,     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_req("rr_next", 32'h0000_00FF, 5'd12, 1'b0, 1'b0, 32'h000F_F000, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
